mult_acc_unit: RTL and testbench
================================

Name: mult_acc_unit

Overview:
- Parametrised sequential shift-add multiplier with accumulator; successor to the fixed 24x16 unsigned multiplier in the EQ filter datapath.
- Adds configurable operand widths, radix (bits retired per cycle), a per-operation signed/unsigned mode and a running MAC accumulator for filter taps.
- Sits between the coefficient ROM / sample delay line and the EQ output stage.
- One operation at a time, start/ready handshake.

Parameters:
- SAMPLE_W, 24: multiplicand (sample) width.
- COEF_W, 16: multiplier (coefficient) width. Must be divisible by RADIX_BITS.
- ACC_W, 48: accumulator width. Must be >= SAMPLE_W+COEF_W.
- RADIX_BITS, 1: coefficient bits consumed per RUN cycle. Legal values are 1, 2 and 4.

Ports:
- i_clk, input, 1: clock; all logic updates on the rising edge.
- i_rst, input, 1: reset, synchronous, active-high.
- i_sample, input, SAMPLE_W: multiplicand.
- i_coefficient, input, COEF_W: multiplier.
- i_start, input, 1: operation request; sampled when o_busy=0.
- i_signed, input, 1: 1 = two's-complement operands, 0 = unsigned. Latched with i_start.
- i_acc_clr, input, 1: 1 = this operation starts a new accumulation. Latched with i_start.
- o_product, output, SAMPLE_W+COEF_W: last completed product.
- o_acc, output, ACC_W: accumulator.
- o_ready, output, 1: one-cycle completion pulse.
- o_busy, output, 1: operation in progress; new starts are ignored while high.

Behaviour:
- Reset: i_rst=1 at a rising edge.
  - State goes to IDLE.
  - o_product=0, o_acc=0, o_ready=0, o_busy=0.
  - Internal operand, partial-sum and counter registers are cleared.
  - An operation in flight is aborted and produces no o_ready.
  - Reset has priority over i_start.
- Define N = COEF_W/RADIX_BITS.
- States:
  - IDLE to RUN: when i_start=1. Latch i_sample, i_coefficient, i_signed and i_acc_clr; clear the partial sum; load counter=N-1. o_busy=1 in RUN.
  - RUN: each cycle add partial product (multiplicand x next RADIX_BITS coefficient digit, LSB first) shifted into the partial sum; decrement counter. When counter=0, go to DONE.
  - DONE: o_ready=1 and o_busy=0. o_product and o_acc update at the edge entering DONE, so they are valid while o_ready=1.
  - DONE to RUN: if i_start=1 (back-to-back accepted).
  - DONE to IDLE: otherwise.
- Latency: i_start sampled at edge k gives o_ready high for the cycle after edge k+N. Back-to-back throughput is one result per N+1 cycles.
- Ignored starts: i_start while o_busy=1 is ignored; no queueing.
- Operand changes: changes to i_sample or i_coefficient after the start edge have no effect.
- Signed mode (i_signed=1):
  - Multiplicand is sign-extended.
  - The most significant coefficient digit is treated as signed, i.e. the coefficient MSB carries weight -2^(COEF_W-1).
  - The product is the exact two's-complement result modulo 2^(SAMPLE_W+COEF_W).
- Unsigned mode (i_signed=0): exact unsigned product.
- Accumulate:
  - Update rule: o_acc <= (acc_clr_latched ? 0 : o_acc) + ext(product).
  - ext is sign-extension if the latched i_signed=1, zero-extension otherwise.
  - Without the optional feature, addition wraps modulo 2^ACC_W.
- Hold: o_product and o_acc hold between completions.

Optional Feature:
- Macro: MULT_ACC_SAT_EN.
- Defined:
  - The accumulator add is saturating.
  - Signed mode: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Unsigned mode: clamp to 2^ACC_W-1.
  - An extra output port o_sat (1 bit, reset 0) pulses with o_ready when clamping occurred.
- Undefined: wrap-around arithmetic and no o_sat port.
- Product computation is identical in both cases.

Test Plan:
- Unsigned, default params: sample=13929842, coef=50645, signed=0, acc_clr=1.
  - o_product=705476848090.
  - o_acc=705476848090.
  - o_ready exactly 17 cycles after the start edge, single pulse.
- Signed, same bit patterns (sample=-2847374, coef=-14891), acc_clr=0 following the previous result:
  - o_product=42400246234.
  - o_acc=747877094324.
- RADIX_BITS=4 instance, signed, sample=-8388608, coef=32767:
  - o_product=-274869518336.
  - o_ready 5 cycles after start.
- ACC_W=40, signed, sample=-8388608, coef=-32768, issued twice (acc_clr=1 then 0):
  - Without MULT_ACC_SAT_EN: o_acc = 274877906944, then -549755813888.
  - With MULT_ACC_SAT_EN: o_acc = 274877906944, then 549755813887, and o_sat=1 on the second o_ready.
- Busy and back-to-back: i_start held high continuously.
  - Starts during RUN are ignored.
  - Results are spaced exactly N+1 cycles apart.
  - Operand changes mid-RUN do not alter o_product.
- Reset mid-operation: i_rst=1 at RUN cycle 5.
  - Next cycle all outputs are 0 and state is IDLE.
  - No o_ready for the aborted operation.
  - A new start completes correctly.

Source files
------------

// File: rtl/mult_acc_unit.sv
// Purpose : sequential shift-add multiplier (RADIX_BITS coefficient bits per cycle)
//           with a running multiply-accumulate register for EQ filter taps.
// Latency : start sampled at edge k -> o_ready for the cycle after edge k+N,
//           N = COEF_W/RADIX_BITS; back-to-back throughput one result per N+1 cycles.
// Backpr. : no queueing; i_start is ignored while o_busy=1. A start seen in the
//           DONE cycle is accepted directly.
//
// Ports   : i_clk, i_rst (sync, active-high); i_sample / i_coefficient operands;
//           i_start request; i_signed / i_acc_clr mode bits latched with i_start;
//           o_product last product; o_acc accumulator; o_ready completion pulse;
//           o_busy operation in progress; o_sat (only with MULT_ACC_SAT_EN).
// Option  : define MULT_ACC_SAT_EN for a saturating accumulator plus o_sat.
module mult_acc_unit #(
    parameter int SAMPLE_W   = 24,
    parameter int COEF_W     = 16,
    parameter int ACC_W      = 48,
    parameter int RADIX_BITS = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [SAMPLE_W-1:0]          i_sample,
    input  logic [COEF_W-1:0]            i_coefficient,
    input  logic                         i_start,
    input  logic                         i_signed,
    input  logic                         i_acc_clr,
    output logic [SAMPLE_W+COEF_W-1:0]   o_product,
    output logic [ACC_W-1:0]             o_acc,
    output logic                         o_ready,
    output logic                         o_busy
`ifdef MULT_ACC_SAT_EN
    ,
    output logic                         o_sat
`endif
);

    localparam int PROD_W = SAMPLE_W + COEF_W;
    localparam int N      = COEF_W / RADIX_BITS;
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q,   state_d;
    logic [PROD_W-1:0] mcand_q,   mcand_d;    // multiplicand, pre-shifted to the current digit weight
    logic [COEF_W-1:0] coef_q,    coef_d;     // remaining coefficient digits, current digit at LSBs
    logic [PROD_W-1:0] psum_q,    psum_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              signed_q,  signed_d;
    logic              acc_clr_q, acc_clr_d;
    logic [PROD_W-1:0] product_q, product_d;
    logic [ACC_W-1:0]  acc_q,     acc_d;
`ifdef MULT_ACC_SAT_EN
    logic              sat_q,     sat_d;
`endif

    logic [PROD_W-1:0] pp;
    logic [PROD_W-1:0] psum_next;
    logic [ACC_W-1:0]  acc_base;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  acc_next;
`ifdef MULT_ACC_SAT_EN
    logic [ACC_W:0]    acc_sum;
    logic [ACC_W-1:0]  acc_clamp;
    logic              acc_ovf;
`endif

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        coef_d    = coef_q;
        psum_d    = psum_q;
        cnt_d     = cnt_q;
        signed_d  = signed_q;
        acc_clr_d = acc_clr_q;
        product_d = product_q;
        acc_d     = acc_q;
`ifdef MULT_ACC_SAT_EN
        sat_d     = 1'b0;   // o_sat only lives for the DONE cycle
`endif

        // Partial product for the current digit. The multiplicand is already
        // sign-extended to PROD_W, so modulo-2^PROD_W adds give the exact result.
        pp = '0;
        for (int b = 0; b < RADIX_BITS; b++) begin
            if (coef_q[b]) begin
                pp = pp + (mcand_q << b);
            end
        end
        // Top digit in signed mode: its MSB weighs -2^(R-1), not +2^(R-1);
        // undo the positive add and subtract once more (net -2x).
        if (signed_q && (cnt_q == '0) && coef_q[RADIX_BITS-1]) begin
            pp = pp - (mcand_q << RADIX_BITS);
        end
        psum_next = psum_q + pp;

        // Accumulator update from the finishing product.
        acc_base = acc_clr_q ? '0 : acc_q;
        if (signed_q) begin
            prod_ext = ACC_W'($signed(psum_next));
        end else begin
            prod_ext = ACC_W'(psum_next);
        end
`ifdef MULT_ACC_SAT_EN
        if (signed_q) begin
            acc_sum   = {acc_base[ACC_W-1], acc_base} + {prod_ext[ACC_W-1], prod_ext};
            acc_ovf   = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
            // Bit ACC_W holds the true sign of the unclamped sum.
            acc_clamp = acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            acc_sum   = {1'b0, acc_base} + {1'b0, prod_ext};
            acc_ovf   = acc_sum[ACC_W];
            acc_clamp = '1;
        end
        acc_next = acc_ovf ? acc_clamp : acc_sum[ACC_W-1:0];
`else
        acc_next = acc_base + prod_ext;
`endif

        case (state_q)
            ST_RUN: begin
                psum_d  = psum_next;
                mcand_d = mcand_q << RADIX_BITS;
                coef_d  = coef_q >> RADIX_BITS;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d   = ST_DONE;
                    product_d = psum_next;
                    acc_d     = acc_next;
`ifdef MULT_ACC_SAT_EN
                    sat_d     = acc_ovf;
`endif
                end
            end
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d   = ST_RUN;
                    if (i_signed) begin
                        mcand_d = PROD_W'($signed(i_sample));
                    end else begin
                        mcand_d = PROD_W'(i_sample);
                    end
                    coef_d    = i_coefficient;
                    signed_d  = i_signed;
                    acc_clr_d = i_acc_clr;
                    psum_d    = '0;
                    cnt_d     = CNT_W'(N - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            coef_q    <= '0;
            psum_q    <= '0;
            cnt_q     <= '0;
            signed_q  <= 1'b0;
            acc_clr_q <= 1'b0;
            product_q <= '0;
            acc_q     <= '0;
`ifdef MULT_ACC_SAT_EN
            sat_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            coef_q    <= coef_d;
            psum_q    <= psum_d;
            cnt_q     <= cnt_d;
            signed_q  <= signed_d;
            acc_clr_q <= acc_clr_d;
            product_q <= product_d;
            acc_q     <= acc_d;
`ifdef MULT_ACC_SAT_EN
            sat_q     <= sat_d;
`endif
        end
    end

    assign o_product = product_q;
    assign o_acc     = acc_q;
    assign o_ready   = (state_q == ST_DONE);
    assign o_busy    = (state_q == ST_RUN);
`ifdef MULT_ACC_SAT_EN
    assign o_sat     = sat_q;
`endif

endmodule

// File: tb/tb_mult_acc_unit.sv
// Bench for mult_acc_unit: three instances (default, RADIX_BITS=4, ACC_W=40)
// sharing operand/reset inputs, each with its own start, checked against a
// plain-arithmetic product/accumulate model.
module tb_mult_acc_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [23:0] smp;
    logic [15:0] coef;
    logic        sg, clr;
    logic        st_d, st_r4, st_a;

    logic [39:0] prod_d, prod_r4, prod_a;
    logic [47:0] acc_d, acc_r4;
    logic [39:0] acc_a;
    logic        rdy_d, rdy_r4, rdy_a;
    logic        busy_d, busy_r4, busy_a;
`ifdef MULT_ACC_SAT_EN
    logic        sat_d, sat_r4, sat_a;
`endif

    int     checks = 0;
    int     errors = 0;
    longint m_acc [3];
    longint obs_p, obs_a;
    logic   obs_s;

    mult_acc_unit u_d (
        .i_clk(clk), .i_rst(rst), .i_sample(smp), .i_coefficient(coef),
        .i_start(st_d), .i_signed(sg), .i_acc_clr(clr),
        .o_product(prod_d), .o_acc(acc_d), .o_ready(rdy_d), .o_busy(busy_d)
`ifdef MULT_ACC_SAT_EN
        , .o_sat(sat_d)
`endif
    );

    mult_acc_unit #(.RADIX_BITS(4)) u_r4 (
        .i_clk(clk), .i_rst(rst), .i_sample(smp), .i_coefficient(coef),
        .i_start(st_r4), .i_signed(sg), .i_acc_clr(clr),
        .o_product(prod_r4), .o_acc(acc_r4), .o_ready(rdy_r4), .o_busy(busy_r4)
`ifdef MULT_ACC_SAT_EN
        , .o_sat(sat_r4)
`endif
    );

    mult_acc_unit #(.ACC_W(40)) u_a (
        .i_clk(clk), .i_rst(rst), .i_sample(smp), .i_coefficient(coef),
        .i_start(st_a), .i_signed(sg), .i_acc_clr(clr),
        .o_product(prod_a), .o_acc(acc_a), .o_ready(rdy_a), .o_busy(busy_a)
`ifdef MULT_ACC_SAT_EN
        , .o_sat(sat_a)
`endif
    );

    // ---------------- reference model ----------------
    function automatic longint sext(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic longint mask(input longint v, input int w);
        return v & ((longint'(1) << w) - 1);
    endfunction

    function automatic longint ref_prod(input logic [23:0] s, input logic [15:0] c, input logic sgn);
        longint a, b;
        a = longint'(s);
        b = longint'(c);
        if (sgn) begin
            a = sext(a, 24);
            b = sext(b, 16);
        end
        return mask(a * b, 40);
    endfunction

    function automatic longint ref_acc(input longint old, input longint p, input logic sgn,
                                       input logic cl, input int w, output logic sat);
        longint base, pv, sum;
        base = cl ? 0 : (sgn ? sext(old, w) : old);
        pv   = sgn ? sext(p, 40) : p;
        sum  = base + pv;
        sat  = 1'b0;
`ifdef MULT_ACC_SAT_EN
        if (sgn) begin
            if (sum > (longint'(1) << (w - 1)) - 1) begin sum = (longint'(1) << (w - 1)) - 1; sat = 1'b1; end
            if (sum < -(longint'(1) << (w - 1)))   begin sum = -(longint'(1) << (w - 1));     sat = 1'b1; end
        end else if (sum > mask(-1, w)) begin
            sum = mask(-1, w);
            sat = 1'b1;
        end
`endif
        return mask(sum, w);
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_out(input int w, output logic r, output logic b,
                              output longint p, output longint a, output logic s);
        s = 1'b0;
        case (w)
            1: begin r = rdy_r4; b = busy_r4; p = longint'(prod_r4); a = longint'(acc_r4);
`ifdef MULT_ACC_SAT_EN
                     s = sat_r4;
`endif
               end
            2: begin r = rdy_a; b = busy_a; p = longint'(prod_a); a = longint'(acc_a);
`ifdef MULT_ACC_SAT_EN
                     s = sat_a;
`endif
               end
            default: begin r = rdy_d; b = busy_d; p = longint'(prod_d); a = longint'(acc_d);
`ifdef MULT_ACC_SAT_EN
                     s = sat_d;
`endif
               end
        endcase
    endtask

    task automatic set_start(input int w, input logic v);
        st_d  = (w == 0) ? v : 1'b0;
        st_r4 = (w == 1) ? v : 1'b0;
        st_a  = (w == 2) ? v : 1'b0;
    endtask

    function automatic int acc_w(input int w);
        return (w == 2) ? 40 : 48;
    endfunction

    // One isolated operation: latency, busy, product, accumulator, single pulse.
    task automatic run_op(input int w, input logic [23:0] s, input logic [15:0] c,
                          input logic sgn, input logic cl);
        int     n, cnt;
        logic   got, r, b, es;
        longint ep, ea;
        n  = (w == 1) ? 4 : 16;
        ep = ref_prod(s, c, sgn);
        ea = ref_acc(m_acc[w], ep, sgn, cl, acc_w(w), es);
        m_acc[w] = ea;
        smp = s; coef = c; sg = sgn; clr = cl;
        set_start(w, 1'b1);
        step();
        set_start(w, 1'b0);
        smp  = 24'($urandom());      // post-start operand changes must not matter
        coef = 16'($urandom());
        sg   = 1'($urandom());
        clr  = 1'($urandom());
        cnt = 0; got = 1'b0;
        while (!got && cnt < n + 4) begin
            step();
            cnt++;
            sample_out(w, r, b, obs_p, obs_a, obs_s);
            if (cnt == 1) chk("busy_in_run", longint'(b), 1);
            if (r) got = 1'b1;
        end
        chk("latency", got ? cnt : -1, n);
        chk("busy_at_ready", longint'(b), 0);
        chk("product", obs_p, ep);
        chk("acc", obs_a, ea);
`ifdef MULT_ACC_SAT_EN
        chk("sat", longint'(obs_s), longint'(es));
`endif
        step();
        sample_out(w, r, b, obs_p, obs_a, obs_s);
        chk("single_pulse", longint'(r), 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        r, b, s;
        longint      p, a;
        logic [23:0] bs [3];
        logic [15:0] bc [3];
        logic        bg [3];
        logic        bl [3];
        longint      bp [3];
        longint      ba [3];
        int          pulses, last, n, nrdy;

        rst = 1'b1; smp = '0; coef = '0; sg = 1'b0; clr = 1'b0;
        st_d = 1'b0; st_r4 = 1'b0; st_a = 1'b0;
        foreach (m_acc[i]) m_acc[i] = 0;
        step(); step();
        rst = 1'b0;
        for (int w = 0; w < 3; w++) begin
            sample_out(w, r, b, p, a, s);
            chk("rst_product", p, 0);
            chk("rst_acc", a, 0);
            chk("rst_ready", longint'(r), 0);
            chk("rst_busy", longint'(b), 0);
        end

        // Directed cases with hand-computed values.
        run_op(0, 24'd13929842, 16'd50645, 1'b0, 1'b1);
        chk("unsigned_prod_lit", obs_p, 64'd705476848090);
        chk("unsigned_acc_lit", obs_a, 64'd705476848090);
        run_op(0, 24'd13929842, 16'd50645, 1'b1, 1'b0);
        chk("signed_prod_lit", obs_p, 64'd42400246234);
        chk("signed_acc_lit", obs_a, 64'd747877094324);
        run_op(1, 24'h800000, 16'h7FFF, 1'b1, 1'b1);
        chk("r4_prod_lit", obs_p, mask(-64'sd274869518336, 40));
        run_op(2, 24'h800000, 16'h8000, 1'b1, 1'b1);
        chk("a40_acc1_lit", obs_a, 64'd274877906944);
        run_op(2, 24'h800000, 16'h8000, 1'b1, 1'b0);
`ifdef MULT_ACC_SAT_EN
        chk("a40_acc2_lit", obs_a, 64'd549755813887);
        chk("a40_sat_lit", longint'(obs_s), 1);
`else
        chk("a40_acc2_lit", obs_a, mask(-64'sd549755813888, 40));
`endif

        // Boundary operands.
        run_op(0, 24'hFFFFFF, 16'hFFFF, 1'b0, 1'b1);
        run_op(0, 24'h800000, 16'h8000, 1'b1, 1'b1);
        run_op(0, 24'h000000, 16'h8000, 1'b1, 1'b0);
        run_op(1, 24'hFFFFFF, 16'hFFFF, 1'b0, 1'b1);
        run_op(1, 24'h7FFFFF, 16'h8000, 1'b1, 1'b0);

        // Back-to-back with start held high; operands change mid-RUN.
        n = 16;
        for (int j = 0; j < 3; j++) begin
            bs[j] = 24'($urandom()); bc[j] = 16'($urandom());
            bg[j] = 1'($urandom());  bl[j] = (j == 0);
            bp[j] = ref_prod(bs[j], bc[j], bg[j]);
            ba[j] = ref_acc(m_acc[0], bp[j], bg[j], bl[j], 48, s);
            m_acc[0] = ba[j];
        end
        smp = bs[0]; coef = bc[0]; sg = bg[0]; clr = bl[0];
        st_d = 1'b1;
        step();
        pulses = 0; last = 0;
        for (int cyc = 1; cyc <= 3 * (n + 1) + 5; cyc++) begin
            step();
            sample_out(0, r, b, p, a, s);
            if (r) begin
                if (pulses < 3) begin
                    chk("b2b_spacing", longint'(cyc - last), (pulses == 0) ? n : n + 1);
                    chk("b2b_product", p, bp[pulses]);
                    chk("b2b_acc", a, ba[pulses]);
                end
                pulses++;
                last = cyc;
            end
            if (cyc == 3)             begin smp = bs[1]; coef = bc[1]; sg = bg[1]; clr = bl[1]; end
            if (cyc == n + 4)         begin smp = bs[2]; coef = bc[2]; sg = bg[2]; clr = bl[2]; end
            if (cyc == 2 * n + 3)     st_d = 1'b0;
            if (cyc == 5 || cyc == n + 6) begin
                smp = 24'($urandom());   // mid-RUN garbage, replaced before the next accept
                coef = 16'($urandom());
                if (cyc == 5) begin smp = bs[1]; coef = bc[1]; end
                else          begin smp = bs[2]; coef = bc[2]; end
            end
        end
        chk("b2b_pulses", longint'(pulses), 3);

        // Reset in the middle of an operation.
        smp = 24'd1234567; coef = 16'd4321; sg = 1'b0; clr = 1'b0;
        st_d = 1'b1;
        step();
        st_d = 1'b0;
        for (int k = 0; k < 4; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        foreach (m_acc[i]) m_acc[i] = 0;
        sample_out(0, r, b, p, a, s);
        chk("midrst_product", p, 0);
        chk("midrst_acc", a, 0);
        chk("midrst_ready", longint'(r), 0);
        chk("midrst_busy", longint'(b), 0);
        nrdy = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (rdy_d) nrdy++;
        end
        chk("midrst_no_ready", longint'(nrdy), 0);
        run_op(0, 24'd1234567, 16'd4321, 1'b0, 1'b0);

        // Randomized operations on the default and radix-4 instances.
        for (int k = 0; k < 24; k++) begin
            run_op(int'($urandom_range(0, 1)), 24'($urandom()), 16'($urandom()),
                   1'($urandom()), ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
